uart_rx: RTL

Receive-side UART deserializer, the counterpart of `uart_tx`. Samples the asynchronous `UART_RX` line, recovers 8N1 frames (optional even parity) at a fixed baud rate and presents each byte on a valid/ready stream interface. Sits between the board pin and any byte consumer (loopback checker, command parser, FIFO).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and baud divider helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    // Integer truncation: the residual baud error is absorbed by mid-bit sampling.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN defined) deserializer with a
// valid/ready byte output and one-cycle frame, parity and overrun pulses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for a falling edge
// START  | counting to start-bit centre to reject glitches
// DATA   | sampling 8 data bits at their centres, LSB first
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit; completes or flags the frame
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      line;
    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      byte_done;
    logic                      frame_bad;
`ifdef UART_RX_PARITY_EN
    logic                      par_q, par_d;
    logic                      parity_bad;
`endif

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (UART_RX),
        .dout (line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_ONE;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        parity_bad = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!line) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    par_d   = line;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (line) begin
                        // Returning to IDLE at stop centre lets a back-to-back start bit be seen.
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) parity_bad = 1'b1;
                        else                   byte_done  = 1'b1;
`else
                        byte_done = 1'b1;
`endif
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (line) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_frame_err <= frame_bad;
            rx_overrun   <= 1'b0;
            if (byte_done && (!rx_data_valid || rx_data_ready)) begin
                rx_data       <= shift_q;
                rx_data_valid <= 1'b1;
            end else begin
                if (byte_done) rx_overrun <= 1'b1;
                if (rx_data_valid && rx_data_ready) rx_data_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_parity_err <= 1'b0;
        else     rx_parity_err <= parity_bad;
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
